// File: rtl/stream_framer.sv
// stream_framer: pops FIFO words and frames them as {8'hA5,seq} header + PAYLOAD_LEN payload words.
// Define STREAM_FRAMER_CHECKSUM_EN to append an XOR-of-payload trailer; the output is one registered valid/ready slot.
module stream_framer #(
   parameter int WIDTH       = 32,
   parameter int PAYLOAD_LEN = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_deq,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sop,
   output logic             out_eop
);

   localparam logic [15:0]      LAST    = 16'(PAYLOAD_LEN - 1);
   localparam logic [WIDTH-9:0] SEQ_ONE = 1;

`ifdef STREAM_FRAMER_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE = 2'd0, PAY = 2'd1, TRL = 2'd2} state_t;
   logic [WIDTH-1:0] csum;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, PAY = 2'd1} state_t;
`endif

   state_t           state;
   logic [WIDTH-9:0] seq;
   logic [15:0]      cnt;
   logic             slot_free;

   assign slot_free = !out_valid || out_ready;
   // Gated by rst so a pop is never issued on the edge that discards the frame.
   assign in_deq    = !rst && (state == PAY) && in_valid && slot_free;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         seq       <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
`ifdef STREAM_FRAMER_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         // A freed slot empties unless one of the loads below refills it.
         if (slot_free) out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid && slot_free) begin
                  out_valid <= 1'b1;
                  out_data  <= {8'hA5, seq};
                  out_sop   <= 1'b1;
                  out_eop   <= 1'b0;
                  seq       <= seq + SEQ_ONE;
                  cnt       <= '0;
`ifdef STREAM_FRAMER_CHECKSUM_EN
                  csum      <= '0;
`endif
                  state     <= PAY;
               end
            end
            PAY: begin
               if (in_deq) begin
                  out_valid <= 1'b1;
                  out_data  <= in_data;
                  out_sop   <= 1'b0;
                  cnt       <= cnt + 16'd1;
`ifdef STREAM_FRAMER_CHECKSUM_EN
                  csum      <= csum ^ in_data;
                  out_eop   <= 1'b0;
                  if (cnt == LAST) state <= TRL;
`else
                  out_eop   <= (cnt == LAST);
                  if (cnt == LAST) state <= IDLE;
`endif
               end
            end
`ifdef STREAM_FRAMER_CHECKSUM_EN
            TRL: begin
               if (slot_free) begin
                  out_valid <= 1'b1;
                  out_data  <= csum;
                  out_sop   <= 1'b0;
                  out_eop   <= 1'b1;
                  state     <= IDLE;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stream_framer.sv
// Randomized bench for stream_framer: FIFO model on the input, frame-stream reference model on the output.
module tb_stream_framer;

   localparam int L = 8;
`ifdef STREAM_FRAMER_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif
   localparam int FLEN = L + 1 + CS;

   logic        clk, rst;
   logic [31:0] in_data, out_data;
   logic        in_valid, in_deq, out_valid, out_ready, out_sop, out_eop;

   logic        rst16;
   logic [15:0] od16;
   logic        ov16, deq16, sop16, eop16;
   logic [15:0] in_data16;
   logic        in_valid16, out_ready16;

   int checks = 0;
   int errors = 0;

   stream_framer #(.WIDTH(32), .PAYLOAD_LEN(L)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_deq(in_deq),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_sop(out_sop), .out_eop(out_eop)
   );

   stream_framer #(.WIDTH(16), .PAYLOAD_LEN(1)) dut16 (
      .clk(clk), .rst(rst16), .in_data(in_data16), .in_valid(in_valid16), .in_deq(deq16),
      .out_data(od16), .out_valid(ov16), .out_ready(out_ready16),
      .out_sop(sop16), .out_eop(eop16)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model / compare process ----------------
   logic [31:0] popped_q[$];
   int          p = 0;
   logic [23:0] mseq = '0;
   logic [31:0] mcs = '0;
   logic        rst_prev = 0, stall_prev = 0, deq_prev = 0;
   logic [31:0] od_prev = '0, word_prev = '0;
   logic        sop_prev = 0, eop_prev = 0;

   always @(negedge clk) begin
      logic [31:0] ew;
      logic        es, ee;
      if (rst_prev) begin
         check("rst_valid", out_valid, 0);
         check("rst_data", out_data, 0);
         check("rst_sop", out_sop, 0);
         check("rst_eop", out_eop, 0);
         check("rst_deq", in_deq, 0);
         p = 0; mseq = '0; mcs = '0;
         popped_q.delete();
         stall_prev = 0; deq_prev = 0;
      end
      if (!rst) begin
         check("deq_while_stalled", in_deq && out_valid && !out_ready, 0);
         check("deq_without_valid", in_deq && !in_valid, 0);
         if (stall_prev) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, od_prev);
            check("stall_flags", {out_sop, out_eop}, {sop_prev, eop_prev});
         end
         if (deq_prev)
            check("pop_latency", {out_valid, out_sop, out_data}, {2'b10, word_prev});
         if (out_valid && out_ready) begin
            es = 0; ee = 0; ew = '0;
            if (p == 0) begin
               ew = {8'hA5, mseq}; es = 1;
               mseq = mseq + 24'd1; mcs = '0;
            end else if (p <= L) begin
               if (popped_q.size() == 0) begin
                  check("payload_before_pop", 0, 1);
               end else begin
                  ew = popped_q.pop_front();
               end
               mcs = mcs ^ ew;
               ee = (p == L) && (CS == 0);
            end else begin
               ew = mcs; ee = 1;
            end
            check("word", {out_sop, out_eop, out_data}, {es, ee, ew});
            p = (p + 1 == FLEN) ? 0 : p + 1;
         end
         deq_prev  = in_deq && in_valid;
         word_prev = in_data;
         if (deq_prev) popped_q.push_back(in_data);
         stall_prev = out_valid && !out_ready;
         od_prev = out_data; sop_prev = out_sop; eop_prev = out_eop;
      end
      rst_prev = rst;
   end

   // ---------------- 16-bit instance: seq wrap ----------------
   int          hdr16_n = 0;
   logic [15:0] h255 = '0, h256 = '0;
   always @(negedge clk) begin
      if (!rst16 && ov16 && sop16) begin
         if (hdr16_n == 255) h255 = od16;
         if (hdr16_n == 256) h256 = od16;
         hdr16_n++;
      end
   end

   // ---------------- stimulus ----------------
   logic [31:0] fifo_q[$];
   logic [33:0] xfer_q[$];
   int          mode = 0;
   logic        starve = 0;
   int          pops = 0;
   logic        last_deq = 0;

   task automatic drive();
      if (mode == 2) starve = ($urandom_range(0, 3) == 0);
      in_valid = !rst && !starve && (fifo_q.size() > 0);
      in_data  = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
      case (mode)
         0:       out_ready = 1'b1;
         1:       out_ready = !out_ready;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic step();
      @(negedge clk);
      last_deq = in_deq;
      if (!rst && out_valid && out_ready) xfer_q.push_back({out_sop, out_eop, out_data});
      @(posedge clk);
      #1;
      if (last_deq && fifo_q.size() > 0) begin
         void'(fifo_q.pop_front());
         pops++;
      end
      drive();
   endtask

   task automatic do_reset();
      rst = 1; fifo_q.delete(); drive();
      step(); step();
      rst = 0; xfer_q.delete(); pops = 0; drive();
   endtask

   task automatic run_until(input int n, input int budget);
      int k = 0;
      while (xfer_q.size() < n && k < budget) begin step(); k++; end
      check("timeout", xfer_q.size() >= n, 1);
   endtask

   task automatic load_seq(input int n);
      for (int i = 1; i <= n; i++) fifo_q.push_back(32'(i));
   endtask

   task automatic load_rand(input int n);
      for (int i = 0; i < n; i++) fifo_q.push_back($urandom);
   endtask

   initial begin
      int k;
      rst = 1; rst16 = 1; in_valid = 0; in_data = 0; out_ready = 1;
      in_valid16 = 1; in_data16 = 16'h1234; out_ready16 = 1;
      do_reset();
      rst16 = 0;

      // basic frame of 1..8
      load_seq(8); drive();
      run_until(FLEN, 100);
      check("t1_header", xfer_q[0], {2'b10, 32'hA500_0000});
      for (int i = 1; i <= L; i++)
         check("t1_payload", xfer_q[i], {1'b0, (i == L) && (CS == 0), 32'(i)});
      if (CS == 1) check("t1_trailer", xfer_q[L+1], {2'b01, 32'h0000_0008});
      for (int i = 0; i < 4; i++) step();

      // 24 words back to back: 3 frames, no bubbles
      do_reset();
      load_rand(24); drive();
      run_until(1, 50);
      k = 0;
      while (xfer_q.size() < 3 * FLEN && k < 200) begin step(); k++; end
      check("t2_cycles", k, 3 * FLEN - 1);
      check("t2_hdr0", xfer_q[0][31:0], 32'hA500_0000);
      check("t2_hdr1", xfer_q[FLEN][31:0], 32'hA500_0001);
      check("t2_hdr2", xfer_q[2*FLEN][31:0], 32'hA500_0002);

      // out_ready toggling every cycle
      do_reset();
      mode = 1; load_rand(16); drive();
      run_until(2 * FLEN, 300);
      mode = 0;

      // underflow after word 3
      do_reset();
      load_seq(8); drive();
      k = 0;
      while (pops < 3 && k < 50) begin step(); k++; end
      check("t4_pops", pops, 3);
      starve = 1; drive();
      for (int i = 0; i < 10; i++) begin
         step();
         check("t4_starved_deq", last_deq, 0);
      end
      starve = 0; drive();
      run_until(FLEN, 100);
      check("t4_last", xfer_q[L], {1'b0, CS == 0, 32'h0000_0008});

      // reset after 4 payload words
      do_reset();
      load_seq(8); drive();
      k = 0;
      while (pops < 4 && k < 50) begin step(); k++; end
      do_reset();
      load_seq(8); drive();
      run_until(FLEN, 100);
      check("t5_header", xfer_q[0], {2'b10, 32'hA500_0000});

      // random traffic and backpressure
      do_reset();
      mode = 2; load_rand(5 * L); drive();
      run_until(5 * FLEN, 2000);
      mode = 0; starve = 0; drive();
      for (int i = 0; i < 4; i++) step();

      // 16-bit seq wrap
      k = 0;
      while (hdr16_n < 257 && k < 2000) begin step(); k++; end
      check("w16_count", hdr16_n >= 257, 1);
      check("w16_hdr_ff", h255, 16'hA5FF);
      check("w16_hdr_00", h256, 16'hA500);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
